// File: rtl/bcd_scan_decoder.sv
// bcd_scan_decoder: latches NUM_DIGITS packed BCD digits and drives a
// time-multiplexed 7-segment display (one-hot digit select, shared segment bus).
// Each digit stays selected for SCAN_DIV clocks. All outputs are registered.
//
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, a zero digit above
// digit 0 whose higher digits are all zero is shown dark (seg = 0) while its
// select line still asserts. When undefined, every digit is decoded normally.

module bcd_scan_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [6:0]              seg,
  output logic                    err
);

  // SCAN_DIV >= 2, so CNT_W is at least 1; a single-digit display still needs
  // a 1-bit index register.
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] latch_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;

  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   sel_d;
  logic [6:0]              seg_d;
  logic                    err_d;

  // 7-segment decode, bit order {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Digit latch: captures bcd_in only on a load strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_q <= '0;
    end else if (load) begin
      latch_q <= bcd_in;
    end
  end

  // Prescaler and scan index: idx advances once per SCAN_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Select the currently scanned digit and build its one-hot enable.
  always_comb begin
    cur_digit = 4'd0;
    sel_d     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = latch_q[4*i +: 4];
        sel_d[i]  = 1'b1;
      end
    end
  end

  // Error flag: any latched digit holding a code above 9.
  always_comb begin
    err_d = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (latch_q[4*i +: 4] > 4'd9) begin
        err_d = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  upper_zero;

  // Walk from the most significant digit down; a digit is blank while it and
  // everything above it is zero. Digit 0 always displays. Invalid codes are
  // non-zero here, so they stop the blanking run.
  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (latch_q[4*i +: 4] == 4'd0);
      if (i != 0) begin
        blank[i] = upper_zero;
      end
    end
  end

  // Pick the blank flag for the scanned digit.
  always_comb begin
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_blank = blank[i];
      end
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  // Segment pattern for the scanned digit.
  always_comb begin
    seg_d = decode(cur_digit);
    if (cur_blank) begin
      seg_d = 7'h00;
    end
  end

  // Output registers: one cycle behind latch/idx; dark during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_sel <= '0;
      seg     <= '0;
      err     <= 1'b0;
    end else begin
      dig_sel <= sel_d;
      seg     <= seg_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Directed bench for bcd_scan_decoder with NUM_DIGITS=4, SCAN_DIV=4.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.

module tb_bcd_scan_decoder;

  localparam int ND = 4;
  localparam int NV = 6;

  logic          clk;
  logic          rst;
  logic          load;
  logic [15:0]   bcd_in;
  logic [3:0]    dig_sel;
  logic [6:0]    seg;
  logic          err;

  int n_checks;
  int n_pass;

  typedef struct packed {
    logic [15:0]     bcd;
    logic [3:0][6:0] segs;  // {digit3, digit2, digit1, digit0}
    logic            err;
  } vec_t;

  vec_t vecs [NV];

  // Zero digits that lie in the leading-zero run.
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  bcd_scan_decoder #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .bcd_in  (bcd_in),
    .dig_sel (dig_sel),
    .seg     (seg),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges, check the dark display, release between edges.
  task automatic do_reset;
    rst    = 1'b1;
    load   = 1'b0;
    bcd_in = 16'h0;
    tick;
    tick;
    check("rst_dig_sel", 32'(dig_sel), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] seen;
    logic [3:0] exp_sel;

    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    load     = 1'b0;
    bcd_in   = 16'h0;

    vecs[0] = '{16'h1234, {7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b0};
    vecs[1] = '{16'h9A05, {7'h6F, 7'h40, 7'h3F, 7'h6D}, 1'b1};
    vecs[2] = '{16'h0070, {LZ, LZ, 7'h07, 7'h3F}, 1'b0};
    vecs[3] = '{16'h8F61, {7'h7F, 7'h40, 7'h7D, 7'h06}, 1'b1};
    vecs[4] = '{16'h0000, {LZ, LZ, LZ, 7'h3F}, 1'b0};
    vecs[5] = '{16'h0B00, {LZ, 7'h40, 7'h3F, 7'h3F}, 1'b1};

    // Post-reset scan with empty latch: 4 edges per digit, starting at digit 0.
    do_reset;
    tick;
    check("first_dig_sel", 32'(dig_sel), 32'h1);
    check("first_seg", 32'(seg), 32'h3F);
    check("first_err", 32'(err), 32'h0);
    for (int e = 2; e <= 17; e++) begin
      tick;
      exp_sel = 4'(1 << (((e - 1) / 4) % 4));
      check($sformatf("scan_e%0d", e), 32'(dig_sel), 32'(exp_sel));
    end

    // Load on the prescaler-wrap edge: next digit already shows the new value.
    do_reset;
    tick;
    tick;
    tick;  // cnt is now SCAN_DIV-1
    load   = 1'b1;
    bcd_in = 16'h1234;
    tick;
    load   = 1'b0;
    bcd_in = 16'hFFFF;
    check("wrap_old_sel", 32'(dig_sel), 32'h1);
    check("wrap_old_seg", 32'(seg), 32'h3F);
    tick;
    check("wrap_new_sel", 32'(dig_sel), 32'h2);
    check("wrap_new_seg", 32'(seg), 32'h4F);
    tick;
    check("wrap_hold_sel", 32'(dig_sel), 32'h2);
    check("wrap_hold_seg", 32'(seg), 32'h4F);

    // Table-driven: load each pattern, then watch one full scan period.
    for (int v = 0; v < NV; v++) begin
      bcd_in = vecs[v].bcd;
      load   = 1'b1;
      tick;
      load   = 1'b0;
      bcd_in = ~vecs[v].bcd;  // latch must ignore this while load is low
      seen   = 4'h0;
      for (int c = 0; c < 16; c++) begin
        tick;
        check($sformatf("v%0d_onehot", v), 32'($onehot(dig_sel)), 32'h1);
        for (int d = 0; d < ND; d++) begin
          if (dig_sel == 4'(1 << d)) begin
            seen[d] = 1'b1;
            check($sformatf("v%0d_seg_d%0d", v, d), 32'(seg), 32'(vecs[v].segs[d]));
          end
        end
        check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].err));
      end
      check($sformatf("v%0d_seen", v), 32'(seen), 32'hF);
    end

    // err latency: two edges from load strobe to visible change, both ways.
    bcd_in = 16'h0000;
    load   = 1'b1;
    tick;
    load   = 1'b0;
    tick;
    check("errlat_clear0", 32'(err), 32'h0);
    bcd_in = 16'h9A05;
    load   = 1'b1;
    tick;
    load   = 1'b0;
    check("errlat_set_e1", 32'(err), 32'h0);
    tick;
    check("errlat_set_e2", 32'(err), 32'h1);
    bcd_in = 16'h0000;
    load   = 1'b1;
    tick;
    load   = 1'b0;
    check("errlat_clr_e1", 32'(err), 32'h1);
    tick;
    check("errlat_clr_e2", 32'(err), 32'h0);

    // Asynchronous reset mid-scan while digit 2 is displayed.
    do_reset;
    bcd_in = 16'hA234;
    load   = 1'b1;
    tick;  // edge 1
    load   = 1'b0;
    for (int e = 2; e <= 10; e++) begin
      tick;
    end
    check("mid_sel", 32'(dig_sel), 32'h4);
    check("mid_seg", 32'(seg), 32'h5B);
    check("mid_err", 32'(err), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_sel", 32'(dig_sel), 32'h0);
    check("async_seg", 32'(seg), 32'h0);
    check("async_err", 32'(err), 32'h0);
    tick;
    check("async_hold_sel", 32'(dig_sel), 32'h0);
    rst = 1'b0;
    tick;
    check("restart_sel", 32'(dig_sel), 32'h1);
    check("restart_seg", 32'(seg), 32'h3F);
    check("restart_err", 32'(err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
